// File: rtl/tipi_chan_bridge.sv
// Bridges a parallel TI-side register file to a bit-serial RPi shift interface.
// Each channel holds TD/TC (TI -> RPi) and RD/RC (RPi -> TI) plus handshake flags.
module tipi_chan_bridge #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned SEL_W    = 1
) (
   input  logic                r_clk,
   input  logic                r_reset,
   input  logic                ti_wr_stb,
   input  logic                ti_rd_stb,
   input  logic [SEL_W-1:0]    ti_sel,
   input  logic                ti_rt,
   input  logic                ti_cd,
   input  logic [WIDTH-1:0]    ti_din,
   output logic [WIDTH-1:0]    ti_dout,
   input  logic [SEL_W-1:0]    r_sel,
   input  logic                r_rt,
   input  logic                r_cd,
   input  logic                r_shift,
   input  logic                r_le,
   input  logic                r_dout,
   output logic                r_din,
   output logic [CHANNELS-1:0] rpi_pending,
   output logic [CHANNELS-1:0] ti_avail,
   output logic                frame_err
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StTx, StRx} state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [WIDTH-1:0]    sr_q;
   logic [WIDTH-1:0]    td_q [CHANNELS];
   logic [WIDTH-1:0]    tc_q [CHANNELS];
   logic [WIDTH-1:0]    rd_q [CHANNELS];
   logic [WIDTH-1:0]    rc_q [CHANNELS];
   logic [WIDTH-1:0]    ti_dout_q;
   logic                r_din_q;
   logic                frame_err_q;
   logic [CHANNELS-1:0] pending_q;
   logic [CHANNELS-1:0] avail_q;

   logic [CHANNELS-1:0] ti_hit, r_hit;
   logic [CHANNELS-1:0] pend_set, pend_clr, avail_set, avail_clr;
   logic [WIDTH-1:0]    ti_rd_val, ld_val;
   logic                load_go, commit_go, cnt_full;

   assign cnt_full  = (cnt_q == CntW'(WIDTH));
   assign load_go   = (state_q == StIdle) && r_le && r_rt;
   assign commit_go = (state_q == StRx) && !r_rt && r_le && cnt_full;

   // Out-of-range selects hit no channel, so reads/loads yield 0 and writes vanish.
   always_comb begin
      ti_hit    = '0;
      r_hit     = '0;
      ti_rd_val = '0;
      ld_val    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         ti_hit[c] = (ti_sel == SEL_W'(c));
         r_hit[c]  = (r_sel == SEL_W'(c));
         if (ti_hit[c]) begin
            ti_rd_val = ti_rt ? (ti_cd ? td_q[c] : tc_q[c]) : (ti_cd ? rd_q[c] : rc_q[c]);
         end
         if (r_hit[c]) begin
            ld_val = r_cd ? td_q[c] : tc_q[c];
         end
      end
   end

   // Sets are applied after clears so a same-cycle set/clear leaves the flag at 1.
   always_comb begin
      pend_set  = (ti_wr_stb && ti_cd) ? ti_hit : '0;
      pend_clr  = (load_go && r_cd) ? r_hit : '0;
      avail_set = (commit_go && r_cd) ? r_hit : '0;
      avail_clr = (ti_rd_stb && !ti_rt && ti_cd) ? ti_hit : '0;
   end

   always_ff @(posedge r_clk or negedge r_reset) begin
      if (!r_reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sr_q        <= '0;
         ti_dout_q   <= '0;
         r_din_q     <= 1'b0;
         frame_err_q <= 1'b0;
         pending_q   <= '0;
         avail_q     <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            td_q[c] <= '0;
            tc_q[c] <= '0;
            rd_q[c] <= '0;
            rc_q[c] <= '0;
         end
      end else begin
         frame_err_q <= 1'b0;
         pending_q   <= (pending_q & ~pend_clr) | pend_set;
         avail_q     <= (avail_q & ~avail_clr) | avail_set;

         if (ti_rd_stb) begin
            ti_dout_q <= ti_rd_val;
         end
         for (int c = 0; c < CHANNELS; c++) begin
            if (ti_wr_stb && ti_hit[c]) begin
               if (ti_cd) td_q[c] <= ti_din;
               else       tc_q[c] <= ti_din;
            end
            if (commit_go && r_hit[c]) begin
               if (r_cd) rd_q[c] <= sr_q;
               else      rc_q[c] <= sr_q;
            end
         end

         unique case (state_q)
            StIdle: begin
               if (r_le) begin
                  if (r_rt) begin
                     sr_q    <= ld_val;
                     cnt_q   <= '0;
                     state_q <= StTx;
                  end
               end else if (r_shift && !r_rt) begin
                  sr_q    <= WIDTH'(r_dout);
                  cnt_q   <= CntW'(1);
                  r_din_q <= r_dout;
                  state_q <= StRx;
               end
            end
            StTx: begin
               if (!r_rt) begin
                  state_q     <= StIdle;
                  cnt_q       <= '0;
                  frame_err_q <= 1'b1;
               end else if (r_le) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (r_shift) begin
                  // Zero fill means a drained register naturally outputs 0.
                  r_din_q <= sr_q[WIDTH-1];
                  sr_q    <= sr_q << 1;
                  if (!cnt_full) cnt_q <= cnt_q + CntW'(1);
               end
            end
            StRx: begin
               if (r_rt) begin
                  state_q     <= StIdle;
                  cnt_q       <= '0;
                  frame_err_q <= 1'b1;
               end else if (r_le) begin
                  if (!cnt_full) frame_err_q <= 1'b1;
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (r_shift) begin
                  sr_q    <= {sr_q[WIDTH-2:0], r_dout};
                  r_din_q <= r_din_q ^ r_dout;
                  if (!cnt_full) cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ti_dout     = ti_dout_q;
   assign r_din       = r_din_q;
   assign rpi_pending = pending_q;
   assign ti_avail    = avail_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tipi_chan_bridge.sv
// Directed bench: runs the same scenario list on an 8-bit/2-channel and a
// 16-bit/4-channel bridge, one at a time, through a shared stimulus bus.
module tb_tipi_chan_bridge;

   logic clk = 1'b0;
   logic rst_n;
   int   cur;
   int   total = 0;
   int   bad = 0;

   logic        d_wr, d_rd, d_trt, d_tcd, d_rt, d_rcd, d_shift, d_le, d_dout;
   logic [1:0]  d_tsel, d_rsel;
   logic [15:0] d_din;
   logic        sa, sb;

   logic [7:0]  a_tdout;
   logic        a_rdin, a_ferr;
   logic [1:0]  a_pend, a_avail;
   logic [15:0] b_tdout;
   logic        b_rdin, b_ferr;
   logic [3:0]  b_pend, b_avail;

   logic [15:0] o_dout;
   logic [3:0]  o_pend, o_avail;
   logic        o_rdin, o_ferr;

   always #5 clk = ~clk;

   assign sa = (cur == 0);
   assign sb = (cur == 1);

   tipi_chan_bridge #(.WIDTH(8), .CHANNELS(2), .SEL_W(1)) dut_a (
      .r_clk      (clk),
      .r_reset    (rst_n),
      .ti_wr_stb  (d_wr & sa),
      .ti_rd_stb  (d_rd & sa),
      .ti_sel     (d_tsel[0]),
      .ti_rt      (d_trt),
      .ti_cd      (d_tcd),
      .ti_din     (d_din[7:0]),
      .ti_dout    (a_tdout),
      .r_sel      (d_rsel[0]),
      .r_rt       (d_rt & sa),
      .r_cd       (d_rcd),
      .r_shift    (d_shift & sa),
      .r_le       (d_le & sa),
      .r_dout     (d_dout),
      .r_din      (a_rdin),
      .rpi_pending(a_pend),
      .ti_avail   (a_avail),
      .frame_err  (a_ferr)
   );

   tipi_chan_bridge #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut_b (
      .r_clk      (clk),
      .r_reset    (rst_n),
      .ti_wr_stb  (d_wr & sb),
      .ti_rd_stb  (d_rd & sb),
      .ti_sel     (d_tsel),
      .ti_rt      (d_trt),
      .ti_cd      (d_tcd),
      .ti_din     (d_din),
      .ti_dout    (b_tdout),
      .r_sel      (d_rsel),
      .r_rt       (d_rt & sb),
      .r_cd       (d_rcd),
      .r_shift    (d_shift & sb),
      .r_le       (d_le & sb),
      .r_dout     (d_dout),
      .r_din      (b_rdin),
      .rpi_pending(b_pend),
      .ti_avail   (b_avail),
      .frame_err  (b_ferr)
   );

   always_comb begin
      o_dout  = sb ? b_tdout : {8'h00, a_tdout};
      o_pend  = sb ? b_pend : {2'b00, a_pend};
      o_avail = sb ? b_avail : {2'b00, a_avail};
      o_rdin  = sb ? b_rdin : a_rdin;
      o_ferr  = sb ? b_ferr : a_ferr;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s (cfg %0d): got %h expected %h", tag, cur, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ti_wr(input logic [1:0] s, input logic cd, input logic [15:0] v);
      d_wr = 1'b1; d_tsel = s; d_tcd = cd; d_din = v;
      step();
      d_wr = 1'b0;
   endtask

   task automatic ti_rd(input logic [1:0] s, input logic rt, input logic cd);
      d_rd = 1'b1; d_tsel = s; d_trt = rt; d_tcd = cd;
      step();
      d_rd = 1'b0;
   endtask

   task automatic r_load(input logic [1:0] s, input logic cd);
      d_le = 1'b1; d_rsel = s; d_rcd = cd;
      step();
      d_le = 1'b0;
   endtask

   task automatic r_sh(input logic b);
      d_shift = 1'b1; d_dout = b;
      step();
      d_shift = 1'b0;
   endtask

   task automatic suite(input int big);
      int          w;
      logic [1:0]  tch;
      logic [3:0]  tbit;
      logic [15:0] txv, rxv, rxv2, got;
      logic        par, b;
      w    = big ? 16 : 8;
      tch  = big ? 2'd3 : 2'd1;
      tbit = big ? 4'b1000 : 4'b0010;
      txv  = big ? 16'hA55A : 16'h00A5;
      rxv  = big ? 16'h3C5A : 16'h003C;
      rxv2 = big ? 16'h0FF1 : 16'h005B;
      cur  = big;

      // Reset state, sampled with the clock still running.
      rst_n = 1'b0;
      #3;
      check("rst_dout", o_dout, 16'h0);
      check("rst_pend", {12'h0, o_pend}, 16'h0);
      check("rst_avail", {12'h0, o_avail}, 16'h0);
      check("rst_rdin", {15'h0, o_rdin}, 16'h0);
      check("rst_ferr", {15'h0, o_ferr}, 16'h0);
      step();
      rst_n = 1'b1;
      step();

      // TI writes TD, RPi loads and shifts it out MSB first.
      ti_wr(tch, 1'b1, txv);
      check("tx_pend_set", {12'h0, o_pend}, {12'h0, tbit});
      ti_rd(tch, 1'b1, 1'b1);
      check("td_readback", o_dout, txv);
      d_rt = 1'b1;
      r_load(tch, 1'b1);
      check("tx_pend_clr", {12'h0, o_pend}, 16'h0);
      for (int i = 0; i < w; i++) begin
         r_sh(1'b0);
         check("tx_bit", {15'h0, o_rdin}, {15'h0, txv[w-1-i]});
      end
      r_sh(1'b0);
      check("tx_sat_zero", {15'h0, o_rdin}, 16'h0);
      r_load(tch, 1'b1);

      // RPi shifts a full frame into RD[0]; parity tracked per bit.
      d_rt = 1'b0;
      par  = 1'b0;
      for (int i = 0; i < w; i++) begin
         b = rxv[w-1-i];
         r_sh(b);
         par ^= b;
         check("rx_parity", {15'h0, o_rdin}, {15'h0, par});
      end
      check("rx_parity_end", {15'h0, o_rdin}, 16'h0);
      r_load(2'd0, 1'b1);
      check("rx_avail_set", {12'h0, o_avail}, 16'h0001);
      ti_rd(2'd0, 1'b0, 1'b1);
      check("rd_readback", o_dout, rxv);
      check("rx_avail_clr", {12'h0, o_avail}, 16'h0);

      // Short frame is discarded with a one-cycle error pulse.
      for (int i = 0; i < 5; i++) r_sh(1'b1);
      r_load(2'd0, 1'b1);
      check("short_ferr", {15'h0, o_ferr}, 16'h0001);
      step();
      check("short_ferr_1cyc", {15'h0, o_ferr}, 16'h0);
      check("short_avail", {12'h0, o_avail}, 16'h0);
      ti_rd(2'd0, 1'b0, 1'b1);
      check("short_rd_kept", o_dout, rxv);

      // Commit and TI read of RD[0] in the same cycle.
      for (int i = 0; i < w; i++) r_sh(rxv2[w-1-i]);
      d_rd = 1'b1; d_tsel = 2'd0; d_trt = 1'b0; d_tcd = 1'b1;
      d_le = 1'b1; d_rsel = 2'd0; d_rcd = 1'b1;
      step();
      d_rd = 1'b0; d_le = 1'b0;
      check("race_rd_old", o_dout, rxv);
      check("race_avail", {12'h0, o_avail}, 16'h0001);
      ti_rd(2'd0, 1'b0, 1'b1);
      check("race_rd_new", o_dout, rxv2);

      // TI write of TD[0] colliding with an RPi load of TD[0].
      ti_wr(2'd0, 1'b1, 16'h0022);
      d_rt = 1'b1;
      d_wr = 1'b1; d_tsel = 2'd0; d_tcd = 1'b1; d_din = 16'h0011;
      d_le = 1'b1; d_rsel = 2'd0; d_rcd = 1'b1;
      step();
      d_wr = 1'b0; d_le = 1'b0;
      check("coll_pend", {12'h0, o_pend}, 16'h0001);
      got = '0;
      for (int i = 0; i < w; i++) begin
         r_sh(1'b0);
         got = {got[14:0], o_rdin};
      end
      check("coll_shift_old", got, 16'h0022);
      r_load(2'd0, 1'b1);
      ti_rd(2'd0, 1'b1, 1'b1);
      check("coll_td_new", o_dout, 16'h0011);

      // Direction change mid-RX aborts; the next shift starts a fresh frame.
      d_rt = 1'b0;
      r_sh(1'b1);
      r_sh(1'b0);
      r_sh(1'b0);
      check("abort_par", {15'h0, o_rdin}, 16'h0001);
      d_rt = 1'b1;
      step();
      check("abort_ferr", {15'h0, o_ferr}, 16'h0001);
      d_rt = 1'b0;
      r_sh(1'b1);
      check("abort_ferr_clr", {15'h0, o_ferr}, 16'h0);
      check("abort_fresh", {15'h0, o_rdin}, 16'h0001);
      r_load(2'd0, 1'b1);
      check("abort_short", {15'h0, o_ferr}, 16'h0001);

      // Reset in the middle of a TX frame clears outputs without a clock edge.
      ti_wr(tch, 1'b1, 16'hFFFF);
      ti_rd(tch, 1'b1, 1'b1);
      check("pre_rst_dout", o_dout, big ? 16'hFFFF : 16'h00FF);
      d_rt = 1'b1;
      r_load(tch, 1'b1);
      r_sh(1'b0);
      r_sh(1'b0);
      check("pre_rst_rdin", {15'h0, o_rdin}, 16'h0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_dout", o_dout, 16'h0);
      check("mid_rst_rdin", {15'h0, o_rdin}, 16'h0);
      check("mid_rst_pend", {12'h0, o_pend}, 16'h0);
      check("mid_rst_ferr", {15'h0, o_ferr}, 16'h0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_ferr", {15'h0, o_ferr}, 16'h0);
      d_rt = 1'b0;
      step();
   endtask

   initial begin
      {d_wr, d_rd, d_trt, d_tcd, d_rt, d_rcd, d_shift, d_le, d_dout} = '0;
      d_tsel = '0;
      d_rsel = '0;
      d_din  = '0;
      cur    = 0;
      rst_n  = 1'b0;
      suite(0);
      suite(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tipi_chan_bridge.md
TIPI_CHAN_BRIDGE -- requirements
Module: tipi_chan_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits; bit 0 is the MSB and is shifted first.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent channels; each channel has registers TD, TC, RD and RC.
REQ-003 SHALL have parameter SEL_W, default 1: width of the channel selects; SEL_W SHALL be at least clog2(CHANNELS).
REQ-004 SHALL use one clock and an asynchronous, active-low reset. Ports r_clk and r_reset are listed first below.
REQ-005 r_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 r_reset  in  1  asynchronous, active-low reset.
REQ-007 ti_wr_stb  in  1  single-cycle TI write strobe, already synchronised to r_clk.
REQ-008 ti_rd_stb  in  1  single-cycle TI read strobe, already synchronised to r_clk.
REQ-009 ti_sel  in  SEL_W  TI-side channel select.
REQ-010 ti_rt  in  1  TI read source: 0 = RD/RC, 1 = TD/TC readback.
REQ-011 ti_cd  in  1  TI register select: 0 = control, 1 = data.
REQ-012 ti_din  in  WIDTH  TI write data.
REQ-013 ti_dout  out  WIDTH  registered TI read data.
REQ-014 r_sel  in  SEL_W  RPi-side channel select.
REQ-015 r_rt  in  1  RPi transfer direction: 1 = TI-to-RPi (TD/TC), 0 = RPi-to-TI (RD/RC).
REQ-016 r_cd  in  1  RPi register select: 0 = control, 1 = data.
REQ-017 r_shift  in  1  one-cycle shift enable; each assertion moves one bit.
REQ-018 r_le  in  1  load/commit strobe.
REQ-019 r_dout  in  1  serial data from the RPi.
REQ-020 r_din  out  1  registered serial data or parity to the RPi.
REQ-021 rpi_pending  out  CHANNELS  TD written by the TI and not yet loaded by the RPi.
REQ-022 ti_avail  out  CHANNELS  RD committed by the RPi and not yet read by the TI.
REQ-023 frame_err  out  1  one-cycle pulse on an aborted or short frame.

Function
REQ-024 The shift engine SHALL implement states IDLE, TX and RX, with a bit counter cnt of width clog2(WIDTH+1) and a WIDTH-bit shift register sr.
REQ-025 In IDLE, r_le with r_rt=1 SHALL load sr from TD/TC[r_sel], set cnt=0, enter TX and clear rpi_pending[r_sel] when r_cd=1.
REQ-026 In TX, each r_shift SHALL set r_din=sr[0], shift sr left with zero fill and increment cnt; at cnt=WIDTH, shifts SHALL output 0 and cnt SHALL saturate.
REQ-027 In IDLE, r_shift with r_rt=0 SHALL enter RX and shift in the first bit; in RX, each r_shift SHALL shift r_dout into sr[WIDTH-1] and increment cnt.
REQ-028 In RX, r_din SHALL equal the even parity (XOR) of all bits shifted in since entering RX, updated one cycle after each shift.
REQ-029 In RX, r_le with cnt=WIDTH SHALL commit sr to RD/RC[r_sel], set ti_avail[r_sel] when r_cd=1, and return to IDLE.
REQ-030 In RX, r_le with cnt!=WIDTH SHALL discard sr, pulse frame_err and return to IDLE.
REQ-031 In TX, r_le SHALL return to IDLE; a new load requires a further r_le while in IDLE.
REQ-032 A change of r_rt while in TX or RX SHALL abort to IDLE, clear cnt and pulse frame_err; no register or flag is written.
REQ-033 If r_le and r_shift are asserted in the same cycle, r_le SHALL take priority and the shift SHALL be ignored.
REQ-034 ti_wr_stb SHALL write ti_din into TD[ti_sel] (ti_cd=1) or TC[ti_sel] (ti_cd=0); a TD write SHALL set rpi_pending[ti_sel].
REQ-035 ti_rd_stb SHALL register the selected register (chosen by ti_rt, ti_cd, ti_sel) into ti_dout with latency 1; ti_dout SHALL hold until the next ti_rd_stb.
REQ-036 A ti_rd_stb of RD with ti_rt=0 and ti_cd=1 SHALL clear ti_avail[ti_sel].
REQ-037 If a TI TD write and an RPi TD load of the same channel occur in the same cycle, sr SHALL receive the old value, TD SHALL receive the new value, and rpi_pending SHALL remain 1.
REQ-038 If an RPi RD commit and a TI RD read of the same channel occur in the same cycle, ti_dout SHALL receive the old value and ti_avail SHALL remain 1.
REQ-039 ti_sel or r_sel values >= CHANNELS SHALL make writes and commits no-ops, make TI reads return 0, and make RPi loads load 0 with no flag change.

Reset
REQ-040 While r_reset=0, all registers, sr, cnt, rpi_pending, ti_avail, ti_dout, r_din and frame_err SHALL be 0 and the state SHALL be IDLE, independent of r_clk.
REQ-041 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse.

Verification
REQ-042 TI writes TD[1]=0xA5 -> rpi_pending=2'b10; r_le with r_rt=1, r_cd=1, r_sel=1, then 8 shifts -> r_din sequence 1,0,1,0,0,1,0,1, and rpi_pending=0 after the load.
REQ-043 r_rt=0, r_cd=1, r_sel=0; shift in 0x3C, then r_le -> RD[0]=0x3C, ti_avail[0]=1, r_din=0 after the 8th shift; ti_rd_stb -> ti_dout=0x3C one cycle later and ti_avail[0]=0.
REQ-044 Shift in 5 bits, then r_le -> frame_err pulses for 1 cycle, RD unchanged, ti_avail unchanged.
REQ-045 Same-cycle TI write of TD[0]=0x11 and RPi load of TD[0] (old value 0x22) -> shifted-out value 0x22, TD[0]=0x11, rpi_pending[0]=1.
REQ-046 Toggle r_rt after 3 RX shifts -> frame_err pulse, state IDLE; assert r_reset mid-TX -> all outputs 0 immediately.
REQ-047 Run REQ-042 to REQ-046 at WIDTH=8, CHANNELS=2 and at WIDTH=16, CHANNELS=4, SEL_W=2.
